// File: rtl/seven_seg_scan.sv
// seven_seg_scan: multiplexed N-digit seven-segment scan driver.
// Hex decode, per-digit decimal point and blanking; new data is staged by
// `load` and committed only at a frame boundary so a frame never tears.
// Optional feature macro: SEVEN_SEG_LZ_BLANK_EN (leading-zero suppression).
module seven_seg_scan #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 200000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  CLK100MHZ,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  output logic [DIGITS-1:0]     Anode_Activate,
  output logic [6:0]            LED_out,
  output logic                  dp_out,
  output logic                  frame_tick
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0]     PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  // XOR masks that turn active-high values into pin polarity (and "off").
  localparam logic [DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [6:0]        SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = (ACTIVE_LOW != 0);

  logic [PW-1:0]       r_pre;
  logic [IW-1:0]       r_idx;
  logic                r_pending;
  logic [4*DIGITS-1:0] r_stg_dig;
  logic [DIGITS-1:0]   r_stg_dp;
  logic [DIGITS-1:0]   r_stg_blank;
  logic [4*DIGITS-1:0] r_dsp_dig;
  logic [DIGITS-1:0]   r_dsp_dp;
  logic [DIGITS-1:0]   r_dsp_blank;
  logic                r_commit_d;

  logic                w_slot_tick;
  logic                w_boundary;
  logic                w_commit;
  logic [4*DIGITS-1:0] w_src_dig;
  logic [DIGITS-1:0]   w_src_dp;
  logic [DIGITS-1:0]   w_src_blank;
  logic [3:0]          w_nib [DIGITS];
  logic [DIGITS-1:0]   w_an;
  logic                w_dark;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: seg_decode = 7'h3F;  4'h1: seg_decode = 7'h06;
      4'h2: seg_decode = 7'h5B;  4'h3: seg_decode = 7'h4F;
      4'h4: seg_decode = 7'h66;  4'h5: seg_decode = 7'h6D;
      4'h6: seg_decode = 7'h7D;  4'h7: seg_decode = 7'h07;
      4'h8: seg_decode = 7'h7F;  4'h9: seg_decode = 7'h6F;
      4'hA: seg_decode = 7'h77;  4'hB: seg_decode = 7'h7C;
      4'hC: seg_decode = 7'h39;  4'hD: seg_decode = 7'h5E;
      4'hE: seg_decode = 7'h79;  default: seg_decode = 7'h71;
    endcase
  endfunction

  assign w_slot_tick = (r_pre == PRE_LAST);
  assign w_boundary  = w_slot_tick && (r_idx == IDX_LAST);
  assign w_commit    = w_boundary && (r_pending || load);
  // A load in the boundary cycle bypasses staging straight into the commit.
  assign w_src_dig   = load ? digits_in : r_stg_dig;
  assign w_src_dp    = load ? dp_in     : r_stg_dp;
  assign w_src_blank = load ? blank_in  : r_stg_blank;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign w_nib[gi] = r_dsp_dig[4*gi +: 4];
    end
  endgenerate

  // Prescaler and scan index: idx steps once per digit slot.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (w_slot_tick) begin
      r_pre <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Staging registers: last load before the boundary wins.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_stg_dig   <= '0;
      r_stg_dp    <= '0;
      r_stg_blank <= '0;
      r_pending   <= 1'b0;
    end else begin
      if (load) begin
        r_stg_dig   <= digits_in;
        r_stg_dp    <= dp_in;
        r_stg_blank <= blank_in;
      end
      if (w_commit)  r_pending <= 1'b0;
      else if (load) r_pending <= 1'b1;
    end
  end

  // Display registers: updated only at a committing frame boundary.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_dsp_dig   <= '0;
      r_dsp_dp    <= '0;
      r_dsp_blank <= '1;
      r_commit_d  <= 1'b0;
    end else begin
      r_commit_d <= w_commit;
      if (w_commit) begin
        r_dsp_dig   <= w_src_dig;
        r_dsp_dp    <= w_src_dp;
        r_dsp_blank <= w_src_blank;
      end
    end
  end

`ifdef SEVEN_SEG_LZ_BLANK_EN
  logic [DIGITS-1:0] r_lz_mask;

  // Zeros with dp clear, from the top digit down, until the first significant one.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] dig,
                                                input logic [DIGITS-1:0]   dp);
    logic lead;
    lz_mask = '0;
    lead    = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (dig[4*i +: 4] == 4'h0) && !dp[i]) lz_mask[i] = 1'b1;
      else                                            lead       = 1'b0;
    end
  endfunction

  // Suppression mask is latched alongside the committed display data.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset)         r_lz_mask <= '0;
    else if (w_commit) r_lz_mask <= lz_mask(w_src_dig, w_src_dp);
  end

  assign w_dark = r_dsp_blank[r_idx] | r_lz_mask[r_idx];
`else
  assign w_dark = r_dsp_blank[r_idx];
`endif

  // One-hot active-high anode for the current scan index.
  always_comb begin
    w_an = '0;
    for (int i = 0; i < DIGITS; i++) w_an[i] = (r_idx == IW'(i));
  end

  // Registered pin drivers: anode, segments and dp always change together.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      Anode_Activate <= AN_OFF;
      LED_out        <= SEG_OFF;
      dp_out         <= DP_OFF;
      frame_tick     <= 1'b0;
    end else begin
      Anode_Activate <= w_an ^ AN_OFF;
      LED_out        <= (w_dark ? 7'h00 : seg_decode(w_nib[r_idx])) ^ SEG_OFF;
      dp_out         <= (!w_dark && r_dsp_dp[r_idx]) ^ DP_OFF;
      frame_tick     <= r_commit_d;
    end
  end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Parametrised multiplexed seven-segment scan driver for N common-anode digits, with hex decoding, per-digit decimal point and blanking. A single internal prescaler sets the refresh rate. A load strobe stages new display data, which is applied only at a frame boundary so a scan frame never tears. The block sits between the numeric datapath and the board's anode/cathode pins, and replaces the single-value, fixed-8-digit display driver.

## Interface
- DIGITS, 8: number of scanned digits, legal 1..16.
- REFRESH_DIV, 200000: CLK100MHZ cycles per digit slot, legal ≥2. At 100 MHz the default gives a 2 ms slot.
- ACTIVE_LOW, 1: 1 = anodes and segments active-low; 0 = active-high.

- CLK100MHZ  input  1  system clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  one-cycle strobe that captures digits_in, dp_in and blank_in into staging.
- digits_in  input  4*DIGITS  hex nibble per digit; digit 0 = bits [3:0].
- dp_in  input  DIGITS  decimal-point enable per digit.
- blank_in  input  DIGITS  1 = digit dark.
- Anode_Activate  output  DIGITS  one-hot digit enable, polarity per ACTIVE_LOW.
- LED_out  output  7  segments {g,f,e,d,c,b,a}, polarity per ACTIVE_LOW.
- dp_out  output  1  decimal-point cathode, polarity per ACTIVE_LOW.
- frame_tick  output  1  one-cycle pulse when display registers are committed at a frame boundary.

## Operation
- Prescaler `pre`, width clog2(REFRESH_DIV):
  - counts 0..REFRESH_DIV-1, then wraps to 0;
  - `slot_tick` is high in the cycle where pre == REFRESH_DIV-1.
- Scan index `idx`, width max(1, clog2(DIGITS)):
  - advances on slot_tick;
  - wraps DIGITS-1 → 0; no unused or out-of-range states are ever entered.
  - Frame boundary = slot_tick while idx == DIGITS-1.
- Staging:
  - `load` writes digits_in, dp_in and blank_in into the staging registers and sets `pending`.
  - A later load before the boundary overwrites staging (last load wins).
- Commit:
  - At a frame boundary with pending set, staging copies into the display registers, pending clears, and frame_tick pulses.
  - With pending clear, there is no commit and no frame_tick.
- Load in the boundary cycle: the commit takes the load's data (bypass), pending ends clear, and frame_tick pulses.
- Decode: hex 0–F.
  - Active-high patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - When ACTIVE_LOW=1, outputs are the bitwise inverse.
- Blanked digit: its anode still asserts during its slot; LED_out and dp_out drive all-off.
- Reset values:
  - pre = 0, idx = 0, pending = 0, staging = 0;
  - display digits = 0, dp = 0, blank mask = all ones (dark until the first commit);
  - Anode_Activate = all off (all 1s when ACTIVE_LOW);
  - LED_out = off, dp_out = off, frame_tick = 0.

## Timing
- All outputs are registered.
- Anode_Activate, LED_out and dp_out update together, in the cycle after slot_tick. There are no glitches between anode and segment changes.
- Each digit is lit for exactly REFRESH_DIV cycles; a frame is DIGITS*REFRESH_DIV cycles.
- After reset deassertion, digit 0 is enabled from the first clock edge, showing blank data.
- Load-to-visible latency: at most one frame plus one cycle; at least one cycle (bypass at the boundary).
- frame_tick is asserted in the same cycle as the first output update of digit 0 for the new frame.
- Reset asserted mid-frame: all state clears immediately (asynchronous), outputs go off, and any staged data is lost.
- DIGITS = 1: idx is constant 0; every slot_tick is a frame boundary.

## Configuration
- SEVEN_SEG_LZ_BLANK_EN, when defined, enables leading-zero suppression:
  - digits scanning from DIGITS-1 down whose committed value is 0 with dp clear are blanked, up to the first non-zero digit or the first digit with dp set;
  - digit 0 is never suppressed.
  - Suppression is evaluated from the display registers at commit time and held in a registered mask.
- Undefined: no suppression logic is built, and zeros display as "0".

## Test plan
- Reset, REFRESH_DIV=4, DIGITS=4 → all anodes off during reset; after release, anodes 1110, 1101, 1011, 0111 for 4 cycles each, then wrap to 1110; LED_out = 7'h7F (blank).
- Load digits_in=16'hA5F0, dp_in=4'b0010, blank_in=0 mid-frame → no change until the boundary; frame_tick pulses once; the digit 0..3 slots show 40, 0E, 12, 08 (active-low); dp_out is low only in the digit-1 slot.
- Two loads in one frame (0x1111, then 0x2222) → only 0x2222 is ever displayed; exactly one frame_tick.
- Load in the boundary cycle with 0x3333 → commit in that cycle; "3" (7'h30) is shown on the first slot of the next frame; pending stays 0 and there is no second frame_tick.
- Reset pulse mid-slot after a commit → outputs are off within the same cycle; after release the display is dark and idx = 0.
- With SEVEN_SEG_LZ_BLANK_EN defined, load 0x0070 → digits 3 and 2 are blank, digits 1 and 0 show "7" and "0"; load 0x0000 → only digit 0 is lit, showing "0".
